shift_deser: RTL

Serial-in, parallel-out frame receiver: the receive end of the parallel-load shift register. It collects a framed serial bit stream one bit per qualified clock, assembles WIDTH-bit words in either bit order, and presents each completed word with a one-cycle valid strobe. It sits downstream of the shift-register serial output in the counters/shift datapath.

---
 rtl/shift_deser_pkg.sv | 18 +
 rtl/shift_deser_sr.sv | 35 +++
 rtl/shift_deser.sv | 124 ++++++++++++
 3 files changed

// File: rtl/shift_deser_pkg.sv
// Shared definitions for the shift_deser serial-in/parallel-out frame receiver.
package shift_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_deser_sr.sv
// Direction-parameterised shift register; next_o is the value the register takes on this edge.
module shift_deser_sr
  import shift_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      // Clear the stale bits so a restarted frame never inherits old data.
      data_d = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit_i} : {bit_i, {(WIDTH-1){1'b0}}};
    end else if (shift_i) begin
      data_d = MSB_FIRST ? {data_q[WIDTH-2:0], bit_i} : {bit_i, data_q[WIDTH-1:1]};
    end
  end

  assign next_o = data_d;

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

endmodule

// File: rtl/shift_deser.sv
// Framed serial receiver: FSM, bit counter and registered outputs around shift_deser_sr.
// Optional even-parity bit after the data bits when SHIFT_DESER_PARITY_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for sin_start
// ST_SHIFT  | collecting data bits 1..WIDTH-1
// ST_PARITY | all data bits in, waiting for the parity bit (parity build only)
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = cnt_w(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("shift_deser: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             qv_q, qv_d;
  logic             fe_q, fe_d;
  logic             pe_q, pe_d;
  logic             sr_load, sr_shift;
  logic [WIDTH-1:0] sr_next;

  shift_deser_sr #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk    (clk),
    .reset  (reset),
    .load_i (sr_load),
    .shift_i(sr_shift),
    .bit_i  (sin),
    .next_o (sr_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    qv_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        sr_load = 1'b1;
        cnt_d   = CW'(1);
        state_d = ST_SHIFT;
        fe_d    = (state_q != ST_IDLE);
      end else begin
        case (state_q)
          ST_SHIFT: begin
            sr_shift = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_DESER_PARITY_EN
              state_d = ST_PARITY;
`else
              word_d  = sr_next;
              qv_d    = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
`endif
            end
          end
`ifdef SHIFT_DESER_PARITY_EN
          // Shifter holds here, so sr_next is the completed data word.
          ST_PARITY: begin
            word_d  = sr_next;
            qv_d    = 1'b1;
            pe_d    = ^{sr_next, sin};
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      qv_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      qv_q    <= qv_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
    end
  end

  assign q          = word_q;
  assign q_valid    = qv_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_err  = fe_q;
  assign parity_err = pe_q;

endmodule
